// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and helpers for the two-requester memory
//                arbiter: FSM state encoding, owner encoding and the
//                address range check.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Owner encoding doubles as the bit index into the {d, i} request vector.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // A byte address is out of range when any bit above the word-index
    // field is set. The address is passed zero-extended to 64 bits so the
    // helper serves any requester width.
    function automatic logic addr_out_of_range(input logic [63:0] addr,
                                               input int          mem_aw);
        return (addr >> (mem_aw + 2)) != 64'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the fetch port, the load/store port and the
//                single-port memory interface around mem_arbiter.
//  Ports       : slave  - arbiter view (requests in, grants/responses and
//                         memory strobes out, mem_rdata in)
//                master - environment view (requesters and memory)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 16
);
    // Fetch requester
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_err;
    // Load/store requester
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_err;
    // Memory port
    logic                  mem_req;
    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_arb_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pick2
//  Description : Combinational two-way picker. A lone request wins outright;
//                when both request, the one that was not served last wins.
//                Holding ptr at OWN_I yields fixed priority (data wins).
//  Ports       : req[1:0] - requests, indexed by owner encoding
//                ptr      - owner served last
//                gnt[1:0] - one-hot grant (or zero)
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[OWN_I] && req[OWN_D]) begin
            if (ptr == OWN_D) begin
                gnt[OWN_I] = 1'b1;
            end else begin
                gnt[OWN_D] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one synchronous single-port memory between the
//                instruction-fetch and load/store paths. One access every
//                two cycles: grant (IDLE/RESP) -> ACCESS -> RESP. Out-of-range
//                addresses complete with err=1 and rdata=0, never touching
//                memory.
//  Ports       : clk, rst  - clock and synchronous active-high reset
//                bus       - mem_arbiter_if.slave (fetch, data, memory)
//  Options     : MEM_ARB_ROUND_ROBIN_EN - round-robin arbitration on
//                contention; otherwise data has fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    state_e                r_state;
    state_e                w_state_nxt;
    owner_e                r_owner;
    logic                  r_oor;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [MEM_AW-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [DATA_W/8-1:0]   r_mem_wstrb;

    logic [1:0]            w_req;
    logic [1:0]            w_pick;
    logic [1:0]            w_gnt;
    logic                  w_can_grant;
    logic                  w_any_gnt;
    logic                  w_sel_d;
    logic [ADDR_W-1:0]     w_addr;
    logic                  w_oor;
    logic                  w_resp;
    owner_e                w_ptr;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_req = {bus.d_req, bus.i_req};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e r_last;

    // Reset value "data served last" hands the first contested grant to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= OWN_D;
        end else if (w_any_gnt) begin
            r_last <= w_sel_d ? OWN_D : OWN_I;
        end
    end

    assign w_ptr = r_last;
`else
    // Pretending fetch was always served last makes data win every tie.
    assign w_ptr = OWN_I;
`endif

    arb_pick2 u_pick (
        .req (w_req),
        .ptr (w_ptr),
        .gnt (w_pick)
    );

    // Grants are only issued when the port is free or about to free up,
    // and never while reset is asserted.
    assign w_can_grant = ((r_state == IDLE) || (r_state == RESP)) && !rst;
    assign w_gnt       = w_can_grant ? w_pick : 2'b00;
    assign w_any_gnt   = |w_gnt;
    assign w_sel_d     = w_gnt[OWN_D];
    assign w_addr      = w_sel_d ? bus.d_addr : bus.i_addr;
    assign w_oor       = addr_out_of_range(64'(w_addr), MEM_AW);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    w_state_nxt = w_any_gnt ? ACCESS : IDLE;
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = w_any_gnt ? ACCESS : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch / memory command registers. The mem_* registers are
    // loaded on the grant edge so they are valid exactly during ACCESS.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= OWN_I;
            r_oor       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            r_mem_req <= w_any_gnt && !w_oor;
            r_mem_we  <= w_any_gnt && w_sel_d && bus.d_we && !w_oor;
            if (w_any_gnt) begin
                r_owner     <= w_sel_d ? OWN_D : OWN_I;
                r_oor       <= w_oor;
                r_mem_addr  <= w_addr[MEM_AW+1:2];
                r_mem_wdata <= w_sel_d ? bus.d_wdata : '0;
                r_mem_wstrb <= w_sel_d ? bus.d_wstrb : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Reset in ACCESS must suppress the strobe in that very
    // cycle, so the registered strobes are gated by rst combinationally;
    // likewise reset in RESP suppresses the response.
    // ------------------------------------------------------------------
    assign bus.i_gnt     = w_gnt[OWN_I];
    assign bus.d_gnt     = w_gnt[OWN_D];

    assign bus.mem_req   = r_mem_req && !rst;
    assign bus.mem_we    = r_mem_we && !rst;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;

    assign w_resp        = (r_state == RESP) && !rst;

    assign bus.i_rvalid  = w_resp && (r_owner == OWN_I);
    assign bus.i_err     = bus.i_rvalid && r_oor;
    assign bus.i_rdata   = (bus.i_rvalid && !r_oor) ? bus.mem_rdata : '0;

    assign bus.d_rvalid  = w_resp && (r_owner == OWN_D);
    assign bus.d_err     = bus.d_rvalid && r_oor;
    assign bus.d_rdata   = (bus.d_rvalid && !r_oor) ? bus.mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a
//                behavioural single-port synchronous memory.
//  Options     : MEM_ARB_ROUND_ROBIN_EN selects round-robin expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MEM_AW(16)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_AW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Synchronous memory: read data appears the cycle after mem_req.
    logic [31:0] mem [0:65535];

    always @(posedge clk) begin
        if (bus.mem_req) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_wstrb[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete access started from IDLE; called at posedge+1.
    task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] exp_rdata, input bit exp_err,
                          input logic [15:0] exp_maddr);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr;
            bus.d_wdata = wdata; bus.d_wstrb = wstrb;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        #1;
        check("gnt", is_d ? bus.d_gnt : bus.i_gnt, 1);
        check("other_gnt", is_d ? bus.i_gnt : bus.d_gnt, 0);
        @(posedge clk); #1;
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        check("mem_req", bus.mem_req, !exp_err);
        check("mem_we", bus.mem_we, we && !exp_err);
        if (!exp_err) check("mem_addr", bus.mem_addr, exp_maddr);
        if (we && !exp_err) begin
            check("mem_wdata", bus.mem_wdata, wdata);
            check("mem_wstrb", bus.mem_wstrb, wstrb);
        end
        check("early_rvalid", bus.i_rvalid | bus.d_rvalid, 0);
        @(posedge clk); #1;
        check("rvalid", is_d ? bus.d_rvalid : bus.i_rvalid, 1);
        check("other_rvalid", is_d ? bus.i_rvalid : bus.d_rvalid, 0);
        check("err", is_d ? bus.d_err : bus.i_err, exp_err);
        if (!we) check("rdata", is_d ? bus.d_rdata : bus.i_rdata, exp_rdata);
        @(posedge clk); #1;
    endtask

    function automatic bit exp_d(input bit use_i, input bit use_d, input int k);
        if (use_i && use_d) return RR ? k[0] : 1'b1;
        return use_d;
    endfunction

    // Requesters hold req continuously for n grants; called at posedge+1.
    task automatic stream(input bit use_i, input bit use_d, input int n);
        int got  = 0;
        int last = 0;
        bus.i_req = use_i; bus.i_addr = 32'h0000_0010;
        bus.d_req = use_d; bus.d_we = 1'b0; bus.d_addr = 32'h0000_2000;
        for (int cyc = 0; cyc < 4 * n && got < n; cyc++) begin
            #1;
            check("one_rvalid", bus.i_rvalid & bus.d_rvalid, 0);
            check("one_gnt", bus.i_gnt & bus.d_gnt, 0);
            if (bus.i_gnt | bus.d_gnt) begin
                check("gnt_owner_d", bus.d_gnt, exp_d(use_i, use_d, got));
                if (got > 0) begin
                    check("gnt_spacing", cyc - last, 2);
                    check("gnt_with_rvalid", bus.i_rvalid | bus.d_rvalid, 1);
                end
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
            if (got == n) begin
                bus.i_req = 1'b0; bus.d_req = 1'b0;
            end
        end
        check("grant_count", got, n);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_wstrb = '0;
        mem[16'h0004] <= 32'h0051_E033;
        mem[16'h0800] <= 32'h1234_5678;
        mem[16'h0000] <= 32'hFFFF_FFFF;
        mem[16'h0C00] <= 32'h1111_1111;

        // Reset state, including requests presented during reset.
        repeat (3) @(posedge clk);
        #1;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        #1;
        check("rst_i_gnt", bus.i_gnt, 0);
        check("rst_d_gnt", bus.d_gnt, 0);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_wstrb", bus.mem_wstrb, 0);
        check("rst_rvalid", {bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err}, 0);
        check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
        @(posedge clk); #1;

        // Fetch of word 4.
        access(1'b0, 1'b0, 32'h0000_0010, '0, '0, 32'h0051_E033, 1'b0, 16'h0004);
        // Half-word store then load back the merged word.
        access(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, '0, 1'b0, 16'h0800);
        check("store_merge", mem[16'h0800], 32'h1234_BEEF);
        access(1'b1, 1'b0, 32'h0000_2000, '0, '0, 32'h1234_BEEF, 1'b0, 16'h0800);
        // Out-of-range load.
        access(1'b1, 1'b0, 32'h0004_0000, '0, '0, 32'h0000_0000, 1'b1, 16'h0000);

        // Reset during ACCESS of a store.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_3000;
        bus.d_wdata = 32'hCAFE_F00D; bus.d_wstrb = 4'hF;
        #1;
        check("abort_gnt", bus.d_gnt, 1);
        @(posedge clk); #1;
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_mem_req", bus.mem_req, 0);
        check("abort_mem_we", bus.mem_we, 0);
        @(posedge clk); #1;
        check("abort_rvalid", bus.d_rvalid | bus.i_rvalid, 0);
        check("abort_mem_addr", bus.mem_addr, 0);
        check("abort_mem_wdata", bus.mem_wdata, 0);
        check("abort_mem_wstrb", bus.mem_wstrb, 0);
        check("abort_rdata", bus.d_rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_no_write", mem[16'h0C00], 32'h1111_1111);
        check("abort_rvalid_after", bus.d_rvalid | bus.i_rvalid, 0);

        // Contention for 8 grants, then fetch-only back-to-back.
        stream(1'b1, 1'b1, 8);
        stream(1'b1, 1'b0, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the core's single unified memory between the instruction-fetch path and the load/store path. It sits between `Core`'s fetch and data units and the `memory` instance, serialising accesses into that memory's single synchronous port. It also returns read data with an out-of-range error flag. It owns no storage beyond one latched request and the arbitration pointer.

## Interface
- `ADDR_W`, 32, byte-address width of both requesters.
- `DATA_W`, 32, data width; byte strobes are `DATA_W/8`.
- `MEM_AW`, 16, log2 of memory depth in words; `mem_addr` is word-indexed.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_req`  in  1  fetch request; held until `i_gnt`.
- `i_addr`  in  ADDR_W  fetch byte address.
- `i_gnt`  out  1  fetch request accepted this cycle.
- `i_rvalid`  out  1  fetch response valid (1 cycle).
- `i_rdata`  out  DATA_W  fetch read data.
- `i_err`  out  1  fetch address out of range; qualifies `i_rvalid`.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_wstrb`  in  DATA_W/8  store byte enables.
- `d_gnt`, `d_rvalid`, `d_rdata`, `d_err`: as fetch equivalents.
- `mem_req`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  MEM_AW  word address, `addr[MEM_AW+1:2]`.
- `mem_wdata`  out  DATA_W  write data.
- `mem_wstrb`  out  DATA_W/8  write byte enables.
- `mem_rdata`  in  DATA_W  read data, valid the cycle after `mem_req`.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any request is pending, pick a winner and pulse its `gnt` combinationally in the same cycle. Latch the owner, we, addr, wdata and wstrb, then go to ACCESS. With no request pending, stay in IDLE.
- ACCESS: drive registered `mem_*` from the latched request with `mem_req`=1, then go to RESP.
- RESP: the owner's `rvalid`=1 and `rdata`=`mem_rdata`; store responses also pulse `rvalid`, with `rdata` don't-care. A new grant may be issued in RESP (next state ACCESS); otherwise go to IDLE.
- Arbitration (base): fixed priority, data beats fetch.
- Out-of-range: if `addr[ADDR_W-1:MEM_AW+2]` is nonzero, the access still takes ACCESS/RESP, but `mem_req` stays 0. The response then carries `err`=1 and `rdata`=0, and no write occurs.
- Low two address bits are ignored; alignment checking belongs to the core.
- The non-owner's `rvalid` is always 0; at most one `gnt` and one `rvalid` are high per cycle.

## Timing
- Reset values: state IDLE; `i_gnt`, `d_gnt`, `i_rvalid`, `d_rvalid`, `i_err`, `d_err`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `mem_wstrb`, `i_rdata`, `d_rdata` = 0; RR pointer = "data last served".
- Latency: `gnt` at cycle N, `mem_req` at N+1, `rvalid` at N+2.
- Throughput: one access per 2 cycles under back-to-back requests.
- Requesters must hold `req` and the request fields stable until `gnt`; fields are sampled only on the `gnt` cycle.
- `rst` in ACCESS or RESP aborts the access: no `rvalid` is issued, and a write in ACCESS is suppressed (`mem_req` forced 0 that cycle). The requester re-requests after reset.
- `gnt` is never asserted while `rst`=1.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: when both request in the same cycle, the requester not served last wins. The pointer updates on every grant, and the first contested grant after reset goes to fetch.
- Undefined: fixed priority, data beats fetch; the pointer register is not built.

## Structure
- Shared package `mem_arb_pkg`: state enum (IDLE/ACCESS/RESP), owner encoding (`OWN_I`=0, `OWN_D`=1), range-check helper.
- One sub-module, `arb_pick2`: combinational 2-way picker taking `req[1:0]` and a pointer and returning a one-hot grant. It is used in RR mode and tied to fixed priority otherwise.

## Test plan
- Reset, then `i_req` with `i_addr`=0x0000_0010 and memory word 4 = 0x0051_E033 -> `i_gnt` at N, `mem_req`/`mem_addr`=4 at N+1, `i_rvalid` with `i_rdata`=0x0051_E033 at N+2.
- `d_req` store to 0x0000_2000 with `d_wdata`=0xDEAD_BEEF and `d_wstrb`=4'b0011, then a load from the same address -> memory word 0x800 low half = 0xBEEF; load returns the merged word, `d_err`=0.
- `i_req` and `d_req` held continuously for 8 grants -> base build: all 8 to data. With `MEM_ARB_ROUND_ROBIN_EN`: grants alternate I,D,I,D,… starting with I.
- `d_req` load from 0x0004_0000 (out of range, `MEM_AW`=16) -> `mem_req` stays 0, `d_rvalid`=1, `d_err`=1, `d_rdata`=0.
- Store granted, `rst` asserted in the ACCESS cycle -> no memory write, no `d_rvalid`, all outputs at reset values the next cycle.
- Fetch requests issued back to back -> `i_gnt` every 2nd cycle, coinciding with the previous `i_rvalid`; no cycle with two `rvalid`s.
